// File: rtl/sequence_player.sv
// ============================================================================
//  Module   : sequence_player
//  Purpose  : Plays entries 0..len-1 of the Simon Says sequence memory onto
//             the LED bus. Each entry is shown ON_CYCLES, then OFF_CYCLES dark.
//             Optional abort input enabled by defining SEQ_PLAYER_ABORT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sequence_player #(
    parameter int WIDTH      = 4,
    parameter int DEPTH_W    = 4,
    parameter int ON_CYCLES  = 8,
    parameter int OFF_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DEPTH_W:0]   len,
    output logic               rd_en,
    output logic [DEPTH_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]   rd_data,
    output logic [WIDTH-1:0]   led,
    output logic               busy,
    output logic               done
`ifdef SEQ_PLAYER_ABORT_EN
    ,
    input  logic               abort
`endif
);

    localparam int c_MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

    localparam logic [c_CNT_W-1:0] c_ON_LOAD  = c_CNT_W'(ON_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_OFF_LOAD = c_CNT_W'(OFF_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [DEPTH_W:0]   c_MAX_LEN  = {1'b1, {DEPTH_W{1'b0}}};
    localparam logic [DEPTH_W:0]   c_LEN_ONE  = (DEPTH_W + 1)'(1);
    localparam logic [DEPTH_W-1:0] c_IDX_ONE  = DEPTH_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_ON    = 3'd3,
        S_OFF   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [DEPTH_W-1:0]   r_idx,   w_idx_nxt;
    logic [c_CNT_W-1:0]   r_cnt,   w_cnt_nxt;
    logic [DEPTH_W:0]     r_n_len, w_n_len_nxt;
    logic [WIDTH-1:0]     r_led,   w_led_nxt;
    logic                 r_busy,  w_busy_nxt;
    logic                 r_done,  w_done_nxt;
    logic                 w_last;

    assign w_last = ({1'b0, r_idx} == (r_n_len - c_LEN_ONE));

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_n_len_nxt = r_n_len;
        w_led_nxt   = r_led;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_n_len_nxt = (len > c_MAX_LEN) ? c_MAX_LEN : len;
                        w_idx_nxt   = '0;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_FETCH: w_state_nxt = S_LATCH;
            S_LATCH: begin
                w_led_nxt   = rd_data;
                w_cnt_nxt   = c_ON_LOAD;
                w_state_nxt = S_ON;
            end
            S_ON: begin
                if (r_cnt == '0) begin
                    w_led_nxt   = '0;
                    w_cnt_nxt   = c_OFF_LOAD;
                    w_state_nxt = S_OFF;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            S_OFF: begin
                if (r_cnt == '0) begin
                    if (w_last) begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + c_IDX_ONE;
                        w_state_nxt = S_FETCH;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            // Clearing idx here keeps rd_addr at 0 throughout IDLE.
            S_DONE: begin
                w_idx_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_idx_nxt   = '0;
                w_led_nxt   = '0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase

`ifdef SEQ_PLAYER_ABORT_EN
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
            w_led_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_n_len <= '0;
            r_led   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_n_len <= w_n_len_nxt;
            r_led   <= w_led_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign rd_en   = (r_state == S_FETCH);
    assign rd_addr = r_idx;
    assign led     = r_led;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sequence_player.sv
// ============================================================================
//  Module   : tb_sequence_player
//  Purpose  : Self-checking bench for sequence_player with a cycle-schedule
//             model and a 1-cycle-latency memory. Define SEQ_PLAYER_ABORT_EN
//             to also exercise abort.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sequence_player;

    localparam int PERIOD = 14;
    localparam int MAXLEN = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] len = '0;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [3:0] rd_data = '0;
    logic [3:0] led;
    logic       busy;
    logic       done;

    logic [3:0] mem [MAXLEN];

    int  cyc = 0;
    bit  m_active = 1'b0;
    int  m_t0 = 0;
    int  m_n = 0;
    int  m_zero_done = -1;
    bit  chk_en = 1'b0;
    int  checks = 0;
    int  failures = 0;

    sequence_player dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .len     (len),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .led     (led),
        .busy    (busy),
        .done    (done)
`ifdef SEQ_PLAYER_ABORT_EN
        ,
        .abort   (abort)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    // Model: playback schedule derived from the start cycle and entry count.
    always @(posedge clk) begin
        int  rel;
        bit  idle;
        rel  = cyc - m_t0;
        idle = !(m_active && rel >= 1 && rel <= PERIOD * m_n + 1);
        if (rst) begin
            m_active    = 1'b0;
            m_zero_done = -1;
        end else if (idle && start) begin
            if (len == 0) begin
                m_zero_done = cyc + 1;
            end else begin
                m_active = 1'b1;
                m_t0     = cyc;
                m_n      = (int'(len) > MAXLEN) ? MAXLEN : int'(len);
            end
        end else if (!idle && abort) begin
            m_active = 1'b0;
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        int rel, k, p;
        int e_led, e_busy, e_done, e_rden, e_addr;
        bit e_addr_chk;
        if (chk_en) begin
            rel        = cyc - m_t0;
            e_led      = 0;
            e_busy     = 0;
            e_done     = (m_zero_done == cyc) ? 1 : 0;
            e_rden     = 0;
            e_addr     = 0;
            e_addr_chk = 1'b1;
            if (m_active && rel >= 1 && rel <= PERIOD * m_n) begin
                k          = (rel - 1) / PERIOD;
                p          = (rel - 1) % PERIOD;
                e_busy     = 1;
                e_done     = 0;
                e_rden     = (p == 0) ? 1 : 0;
                e_addr     = k;
                e_addr_chk = (p == 0);
                e_led      = (p >= 2 && p <= 9) ? int'(mem[k]) : 0;
            end else if (m_active && rel == PERIOD * m_n + 1) begin
                e_done     = 1;
                e_addr_chk = 1'b0;
            end
            check("model_led", int'(led), e_led);
            check("model_busy", int'(busy), e_busy);
            check("model_done", int'(done), e_done);
            check("model_rd_en", int'(rd_en), e_rden);
            if (e_addr_chk) check("model_rd_addr", int'(rd_addr), e_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic go(input int l, output int t0);
        len   = l[4:0];
        start = 1'b1;
        t0    = cyc;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int t;
        for (int i = 0; i < MAXLEN; i++) mem[i] = 4'(i ^ 9);
        mem[0] = 4'b1110;
        mem[1] = 4'b0001;
        mem[2] = 4'b0010;
        mem[3] = 4'b0100;
        mem[5] = 4'b0000;

        rst = 1'b1;
        repeat (2) tick();
        check("reset_led", int'(led), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_rd_en", int'(rd_en), 0);
        rst    = 1'b0;
        chk_en = 1'b1;
        repeat (2) tick();

        // Single entry
        go(1, t);
        wait_to(t + 1);
        check("len1_rd_en_c1", int'(rd_en), 1);
        check("len1_rd_addr_c1", int'(rd_addr), 0);
        wait_to(t + 3);  check("len1_led_c3", int'(led), 'b1110);
        wait_to(t + 10); check("len1_led_c10", int'(led), 'b1110);
        wait_to(t + 11); check("len1_led_c11", int'(led), 0);
        wait_to(t + 14); check("len1_busy_c14", int'(busy), 1);
        wait_to(t + 15);
        check("len1_done_c15", int'(done), 1);
        check("len1_busy_c15", int'(busy), 0);
        wait_to(t + 16); check("len1_done_c16", int'(done), 0);
        repeat (3) tick();

        // Three entries
        go(3, t);
        wait_to(t + 15); check("len3_rd_addr_c15", int'(rd_addr), 1);
        wait_to(t + 17); check("len3_led_c17", int'(led), 'b0001);
        wait_to(t + 29);
        check("len3_rd_en_c29", int'(rd_en), 1);
        check("len3_rd_addr_c29", int'(rd_addr), 2);
        wait_to(t + 31); check("len3_led_c31", int'(led), 'b0010);
        wait_to(t + 42); check("len3_done_c42", int'(done), 0);
        wait_to(t + 43); check("len3_done_c43", int'(done), 1);
        repeat (2) tick();

        // Zero length
        go(0, t);
        check("len0_done_c1", int'(done), 1);
        check("len0_busy_c1", int'(busy), 0);
        tick();
        check("len0_done_c2", int'(done), 0);
        repeat (2) tick();

        // Start and len change while busy are ignored
        go(2, t);
        wait_to(t + 5);
        len   = 5'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_to(t + 28); check("ign_busy_c28", int'(busy), 1);
        wait_to(t + 29); check("ign_done_c29", int'(done), 1);
        repeat (2) tick();

        // Reset mid-playback, then replay from address 0
        go(3, t);
        wait_to(t + 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_led_c7", int'(led), 0);
        check("rst_busy_c7", int'(busy), 0);
        check("rst_done_c7", int'(done), 0);
        tick();
        go(1, t);
        wait_to(t + 1);
        check("replay_rd_addr_c1", int'(rd_addr), 0);
        wait_to(t + 3);  check("replay_led_c3", int'(led), 'b1110);
        wait_to(t + 17);

        // Oversized len clamps to 16 entries; entry 5 is a dark ON phase
        go(31, t);
        wait_to(t + PERIOD * 5 + 3);
        check("clamp_zero_led", int'(led), 0);
        check("clamp_zero_busy", int'(busy), 1);
        wait_to(t + PERIOD * 15 + 1);
        check("clamp_rd_addr_15", int'(rd_addr), 15);
        wait_to(t + PERIOD * 16 + 1);
        check("clamp_done", int'(done), 1);
        repeat (2) tick();

`ifdef SEQ_PLAYER_ABORT_EN
        go(2, t);
        wait_to(t + 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_led_c5", int'(led), 0);
        check("abort_busy_c5", int'(busy), 0);
        wait_to(t + 40);
        abort = 1'b1;
        go(1, t);
        abort = 1'b0;
        check("abort_start_wins", int'(busy), 1);
        wait_to(t + 18);
`endif

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
